// File: rtl/rominit_seq.sv
// rominit_seq: streams loader bytes into the boot, chr and cart ROM regions and
// holds the console core in reset until both boot and chr images are loaded.
module rominit_seq #(
  parameter int BOOT_SIZE = 4096,
  parameter int CHR_SIZE  = 1024,
  parameter int CART_MAX  = 131072,
  parameter int WR_GAP    = 0
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        LD_START,
  input  logic [1:0]  LD_REGION,
  input  logic [7:0]  LD_DATA,
  input  logic        LD_VALID,
  input  logic        LD_LAST,
  output logic        LD_READY,
  output logic        ROMINIT_SEL_BOOT,
  output logic        ROMINIT_SEL_CHR,
  output logic        ROMINIT_SEL_CART,
  output logic [24:0] ROMINIT_ADDR,
  output logic [7:0]  ROMINIT_DATA,
  output logic        ROMINIT_VALID,
  output logic        DONE_BOOT,
  output logic        DONE_CHR,
  output logic        DONE_CART,
  output logic        ERR,
  output logic        SYS_RES
);

  // IDLE wait for start | SETUP raise select | XFER take bytes | GAP pace writes | FLUSH drop select
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_XFER, S_GAP, S_FLUSH} state_t;

  localparam logic [15:0] GAP_LOAD = (WR_GAP > 0) ? 16'(WR_GAP - 1) : 16'd0;

  state_t      state, state_nxt;
  logic [1:0]  region;
  logic [24:0] count, limit, last_len;
  logic [15:0] gap_cnt;
  logic        accept, at_limit, start_ok, start_bad;

  always_comb begin
    case (region)
      2'd0:    limit = 25'(BOOT_SIZE);
      2'd1:    limit = 25'(CHR_SIZE);
      default: limit = 25'(CART_MAX);
    endcase
  end

  assign at_limit = (count == limit);
  assign last_len = count + 25'd1;

  always_comb begin
    state_nxt = state;
    LD_READY  = 1'b0;
    accept    = 1'b0;
    start_ok  = 1'b0;
    start_bad = 1'b0;
    case (state)
      S_IDLE: begin
        if (LD_START) begin
          if (LD_REGION != 2'd3) begin
            start_ok  = 1'b1;
            state_nxt = S_SETUP;
          end else begin
            start_bad = 1'b1;
          end
        end
      end
      S_SETUP: state_nxt = S_XFER;
      S_XFER: begin
        // limit check precedes any accept, so the counter can never pass the region size
        if (at_limit) begin
          state_nxt = S_FLUSH;
        end else begin
          LD_READY = 1'b1;
          if (LD_VALID) begin
            accept = 1'b1;
            if (LD_LAST)         state_nxt = S_FLUSH;
            else if (WR_GAP > 0) state_nxt = S_GAP;
          end
        end
      end
      S_GAP:   if (gap_cnt == 16'd0) state_nxt = S_XFER;
      S_FLUSH: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      region        <= 2'd0;
      count         <= 25'd0;
      gap_cnt       <= 16'd0;
      ROMINIT_ADDR  <= 25'd0;
      ROMINIT_DATA  <= 8'd0;
      ROMINIT_VALID <= 1'b0;
      DONE_BOOT     <= 1'b0;
      DONE_CHR      <= 1'b0;
      DONE_CART     <= 1'b0;
      ERR           <= 1'b0;
    end else begin
      ROMINIT_VALID <= accept;
      if (accept) begin
        ROMINIT_ADDR <= count;
        ROMINIT_DATA <= LD_DATA;
        count        <= last_len;
        gap_cnt      <= GAP_LOAD;
      end else if (state == S_GAP) begin
        gap_cnt <= gap_cnt - 16'd1;
      end
      if (start_ok) begin
        region <= LD_REGION;
        count  <= 25'd0;
        ERR    <= 1'b0;
        case (LD_REGION)
          2'd0:    DONE_BOOT <= 1'b0;
          2'd1:    DONE_CHR  <= 1'b0;
          default: DONE_CART <= 1'b0;
        endcase
      end
      if (start_bad || (state == S_XFER && at_limit)) ERR <= 1'b1;
      // boot and chr must be filled exactly; any non-empty cart image is accepted
      if (accept && LD_LAST) begin
        case (region)
          2'd0: if (last_len == limit) DONE_BOOT <= 1'b1; else ERR <= 1'b1;
          2'd1: if (last_len == limit) DONE_CHR  <= 1'b1; else ERR <= 1'b1;
          default: DONE_CART <= 1'b1;
        endcase
      end
    end
  end

  assign ROMINIT_SEL_BOOT = (state != S_IDLE) && (region == 2'd0);
  assign ROMINIT_SEL_CHR  = (state != S_IDLE) && (region == 2'd1);
  assign ROMINIT_SEL_CART = (state != S_IDLE) && (region == 2'd2);
  assign SYS_RES          = !(DONE_BOOT && DONE_CHR && state == S_IDLE);

endmodule
